// File: rtl/pwm_comp_gen.sv
// Complementary half-bridge PWM with dead time, period-aligned setting updates,
// current-sense blanking window and a latched fault shutdown.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RUN       | normal switching, gates follow the counter compare
// ST_FAULT     | fault seen, gates forced low, fault_latched asserted
// ST_WAIT_SYNC | fault cleared, gates held low until the next period start
module pwm_comp_gen #(
  parameter int WIDTH   = 11,
  parameter int DT_W    = 8,
  parameter int BLANK_W = 8,
  parameter int MIN_DT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   duty,
  input  logic [DT_W-1:0]    deadtime,
  input  logic [BLANK_W-1:0] blank_len,
  input  logic               fault,
  input  logic               fault_clr,
  output logic               PWM1,
  output logic               PWM2,
  output logic               PWM_synch,
  output logic               ovr_I_blank,
  output logic               fault_latched
);

  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FAULT     = 2'd1,
    ST_WAIT_SYNC = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   duty_act;
  logic [DT_W-1:0]    dt_act;
  logic [BLANK_W-1:0] blank_act;
  logic [DT_W-1:0]    dt_clamped;
  logic               at_end;
  logic               shadow_ld;
  logic               fault_block;

  logic [SW-1:0] cnt_x;
  logic [SW-1:0] duty_x;
  logic [SW-1:0] dt_x;
  logic [SW-1:0] blank_x;
  logic [SW-1:0] e1;
  logic [SW-1:0] lo_end;
  logic [SW-1:0] hi_end;

  logic pwm1_nxt;
  logic pwm2_nxt;
  logic blank_nxt;

  assign at_end    = (cnt == CNT_MAX);
  assign shadow_ld = ~en | at_end;
  assign dt_clamped = (deadtime < DT_W'(MIN_DT)) ? DT_W'(MIN_DT) : deadtime;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Settings only change at the period boundary (or continuously while stopped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act  <= '0;
      dt_act    <= '0;
      blank_act <= '0;
    end else if (shadow_ld) begin
      duty_act  <= duty;
      dt_act    <= dt_clamped;
      blank_act <= blank_len;
    end
  end

  // Widened arithmetic so the end points never wrap past the period.
  assign cnt_x   = SW'(cnt);
  assign duty_x  = SW'(duty_act);
  assign dt_x    = SW'(dt_act);
  assign blank_x = SW'(blank_act);
  assign e1      = duty_x + dt_x;
  assign lo_end  = dt_x + blank_x;
  assign hi_end  = e1 + blank_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (fault) state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clr && !fault) state_nxt = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (fault)       state_nxt = ST_FAULT;
        else if (at_end) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_FAULT;
    endcase
  end

  // A fault input blocks the gates on the very edge it is sampled.
  assign fault_block = (state != ST_RUN) | fault;

  always_comb begin
    pwm1_nxt  = 1'b0;
    pwm2_nxt  = 1'b0;
    blank_nxt = 1'b0;
    if (en) begin
      pwm1_nxt  = (cnt_x >= dt_x) && (cnt_x < duty_x) && !fault_block;
      pwm2_nxt  = (cnt_x >= e1) && !fault_block;
      blank_nxt = ((duty_x > dt_x) && (cnt_x >= dt_x) && (cnt_x < lo_end)) ||
                  ((cnt_x >= e1) && (cnt_x < hi_end));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PWM1        <= 1'b0;
      PWM2        <= 1'b0;
      ovr_I_blank <= 1'b0;
    end else begin
      PWM1        <= pwm1_nxt;
      PWM2        <= pwm2_nxt;
      ovr_I_blank <= blank_nxt;
    end
  end

  // Strobe is also held low while reset is asserted.
  assign PWM_synch     = en & rst_n & (cnt == '0);
  assign fault_latched = (state == ST_FAULT);

endmodule

// File: tb/tb_pwm_comp_gen.sv
// Randomised bench for pwm_comp_gen against an interval-based reference model.
module tb_pwm_comp_gen;

  localparam int P    = 2048;
  localparam int NCYC = 38000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [10:0] duty;
  logic [7:0]  deadtime;
  logic [7:0]  blank_len;
  logic        fault;
  logic        fault_clr;
  logic        PWM1;
  logic        PWM2;
  logic        PWM_synch;
  logic        ovr_I_blank;
  logic        fault_latched;

  pwm_comp_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .duty         (duty),
    .deadtime     (deadtime),
    .blank_len    (blank_len),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .PWM1         (PWM1),
    .PWM2         (PWM2),
    .PWM_synch    (PWM_synch),
    .ovr_I_blank  (ovr_I_blank),
    .fault_latched(fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model: position in period, active settings, fault status (0 run, 1 faulted, 2 awaiting period)
  int m_cnt, m_duty, m_dt, m_blank, m_state;
  int e_p1, e_p2, e_blk;
  int en_off;
  bit rst_done;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t cnt=%0d)", tag, obs, exp, $time, m_cnt);
    end
  endtask

  function automatic bit in_win(input int x, input int lo, input int hi);
    return (x >= lo) && (x < hi);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_dt = 0; m_blank = 0; m_state = 0;
    e_p1 = 0; e_p2 = 0; e_blk = 0;
  endtask

  // One clock edge of the reference, using the inputs currently applied.
  task automatic model_edge();
    int  e1;
    bit  blocked;
    e1      = m_duty + m_dt;
    blocked = (m_state != 0) || fault;
    if (en) begin
      e_p1  = in_win(m_cnt, m_dt, m_duty) && !blocked;
      e_p2  = in_win(m_cnt, e1, P) && !blocked;
      e_blk = (m_duty > m_dt && in_win(m_cnt, m_dt, m_dt + m_blank)) ||
              in_win(m_cnt, e1, e1 + m_blank);
    end else begin
      e_p1 = 0; e_p2 = 0; e_blk = 0;
    end
    if (m_state == 0) begin
      if (fault) m_state = 1;
    end else if (m_state == 1) begin
      if (fault_clr && !fault) m_state = 2;
    end else begin
      if (fault) m_state = 1;
      else if (m_cnt == P - 1) m_state = 0;
    end
    if (!en || m_cnt == P - 1) begin
      m_duty  = int'(duty);
      m_dt    = (int'(deadtime) < 1) ? 1 : int'(deadtime);
      m_blank = int'(blank_len);
    end
    m_cnt = en ? (m_cnt + 1) % P : 0;
  endtask

  task automatic check_regs();
    check_val("pwm1", int'(PWM1), e_p1);
    check_val("pwm2", int'(PWM2), e_p2);
    check_val("ovr_i_blank", int'(ovr_I_blank), e_blk);
    check_val("fault_latched", int'(fault_latched), (m_state == 1) ? 1 : 0);
    check_val("no_overlap", int'(PWM1 & PWM2), 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    duty = '0; deadtime = '0; blank_len = '0;
    en_off = 0; rst_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_regs();
    check_val("synch_reset", int'(PWM_synch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    duty = 11'h400; deadtime = 8'h40; blank_len = 8'h80;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      fault = 1'b0;
      fault_clr = 1'b0;
      // directed scenarios, aligned to period starts while en stays high
      if (cyc == P + 'h200)       duty = 11'h100;
      if (cyc == 2*P - 100)       begin duty = 11'h7F0; deadtime = 8'h40; end
      if (cyc == 3*P - 100)       duty = 11'h020;
      if (cyc == 4*P - 100)       begin duty = 11'h300; deadtime = 8'h00; blank_len = 8'h10; end
      if (cyc == 5*P - 100)       begin duty = 11'h400; deadtime = 8'h40; blank_len = 8'h80; end
      if (cyc == 5*P + 'h100)     fault = 1'b1;
      if (cyc == 5*P + 'h300)     fault_clr = 1'b1;
      if (cyc == 6*P + 'h100)     fault = 1'b1;
      if (cyc == 6*P + 'h200)     begin fault = 1'b1; fault_clr = 1'b1; end
      if (cyc == 6*P + 'h400)     fault_clr = 1'b1;
      if (cyc == 7*P + 'h300)     en_off = 10;
      if (cyc >= 8*P) begin
        if ($urandom_range(0, 299) == 0) begin
          case ($urandom_range(0, 3))
            0: duty = 11'($urandom_range(0, P - 1));
            1: duty = 11'h000;
            2: duty = 11'h7FF;
            default: duty = 11'($urandom_range(1980, P - 1));
          endcase
          deadtime  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1))
                                                  : 8'($urandom_range(0, 255));
          blank_len = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        end
        fault     = ($urandom_range(0, 1999) == 0);
        fault_clr = ($urandom_range(0, 599) == 0) || (fault && $urandom_range(0, 1) == 1);
        if (cyc < 30000 && en_off == 0 && $urandom_range(0, 2999) == 0)
          en_off = $urandom_range(1, 20);
      end
      if (en_off > 0) begin
        en = 1'b0;
        en_off--;
      end else begin
        en = 1'b1;
      end
      #1;
      check_val("pwm_synch", int'(PWM_synch), (en && m_cnt == 0) ? 1 : 0);
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
      if (!rst_done && cyc >= 33000 && m_cnt == 'h500 && en) begin
        rst_done = 1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_val("synch_in_reset", int'(PWM_synch), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    check_val("reset_exercised", int'(rst_done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_comp_gen.md
Name: pwm_comp_gen

Overview:
Parametrised complementary PWM generator with programmable dead time, double-buffered settings, programmable over-current blanking and a latched fault shutdown.
- Next generation of the fixed 11-bit motor-drive PWM.
- Drives the high/low gate pair of one half-bridge.
- Supplies the period-start strobe and the current-sense blanking window to the rest of the drive path.

Parameters:
WIDTH, 11, counter/duty width; PWM period = 2^WIDTH clk cycles
DT_W, 8, width of deadtime input
BLANK_W, 8, width of blank_len input
MIN_DT, 1, minimum effective dead time in clk cycles; smaller programmed values are clamped up to MIN_DT

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  run enable
duty  in  WIDTH  requested duty (PWM1 end point)
deadtime  in  DT_W  requested non-overlap time, clk cycles
blank_len  in  BLANK_W  blanking window length, clk cycles
fault  in  1  synchronous over-current/fault level
fault_clr  in  1  single-cycle fault clear request
PWM1  out  1  first-phase gate drive
PWM2  out  1  second-phase gate drive
PWM_synch  out  1  period-start strobe
ovr_I_blank  out  1  over-current comparator blanking
fault_latched  out  1  sticky fault status

Behaviour:
- Reset: cnt=0, all shadow registers=0, and every output (PWM1, PWM2, PWM_synch, ovr_I_blank, fault_latched) is 0. Reset takes effect immediately, including mid-period.
- Counter cnt (WIDTH bits):
  - en=1: increments every clk and wraps from 2^WIDTH-1 to 0.
  - en=0: cnt is held at 0.
- PWM_synch = en & (cnt==0). It is combinational from registered cnt.
- Shadow registers duty_act, dt_act, blank_act:
  - Loaded from the inputs on the edge where cnt==2^WIDTH-1, so new values take effect exactly at cnt==0.
  - While en=0 they load every cycle.
  - There are no mid-period changes.
  - dt_act = max(deadtime, MIN_DT).
- Sums are computed at WIDTH+2 bits, so they never wrap:
  - E1 = duty_act + dt_act
  - Blank window end points: dt_act+blank_act and E1+blank_act
- Outputs PWM1, PWM2 and ovr_I_blank are registered and reflect the cnt value of the previous cycle (1-cycle latency). While en=0 they are 0.
- PWM1 next = (cnt >= dt_act) & (cnt < duty_act) & ~fault_block.
- PWM2 next = (cnt >= E1) & ~fault_block.
  - PWM2 drops at wrap because cnt returns to 0 < E1.
  - If E1 > 2^WIDTH-1, PWM2 stays low all period.
- Overlap guarantee: PWM1 and PWM2 are never both 1, and there are at least dt_act low cycles between opposite edges, including across the wrap.
- Edge cases:
  - duty_act <= dt_act: PWM1 is never high.
  - duty_act = 0: PWM2 is high from dt_act to the end of the period.
- ovr_I_blank next = lower window | upper window, where:
  - lower window: (dt_act <= cnt < dt_act+blank_act), only if duty_act > dt_act
  - upper window: (E1 <= cnt < E1+blank_act), only if E1 <= 2^WIDTH-1
  - Windows are truncated at the period end and never wrap into the next period.
  - blank_act = 0 gives no blanking.
- Fault handling, with states RUN, FAULT and WAIT_SYNC:
  - RUN -> FAULT when fault=1 is sampled. On that same edge PWM1=PWM2=0 and fault_latched=1.
  - In FAULT, fault_block=1.
  - FAULT -> WAIT_SYNC on fault_clr=1 & fault=0. fault_latched goes to 0 on that edge.
  - If fault=1 and fault_clr=1 arrive together, fault wins and the block stays in FAULT.
  - In WAIT_SYNC, fault_block=1.
  - WAIT_SYNC -> RUN on the edge where cnt==2^WIDTH-1, so outputs resume at the period start.
  - fault=1 in WAIT_SYNC returns the block to FAULT.
  - The counter, PWM_synch and ovr_I_blank keep running during FAULT and WAIT_SYNC.
  - en=0 does not clear the fault state.

Test Plan:
1. Nominal (WIDTH=11, duty=0x400, deadtime=0x40, blank_len=0x80):
   - PWM1=1 for previous-cycle cnt 0x040–0x3FF; PWM2=1 for cnt 0x440–0x7FF.
   - ovr_I_blank=1 for cnt 0x040–0x0BF and 0x440–0x4BF.
   - PWM_synch pulses once per 2048 clks.
2. Duty changed 0x400→0x100 at cnt=0x200: current period is unchanged; next period has PWM1 0x040–0x0FF and PWM2 from 0x140.
3. Boundaries:
   - duty=0x7F0, deadtime=0x40 → PWM2 never high, no upper blank window.
   - duty=0x020, deadtime=0x40 → PWM1 never high, PWM2 from 0x060.
   - deadtime=0 → effective dead time 1.
4. Fault:
   - fault=1 for 1 cycle at cnt=0x100 → PWM1/PWM2 go 0 on the next edge and fault_latched=1.
   - fault_clr at cnt=0x300 → fault_latched=0; outputs stay 0 until cnt==0, then follow the normal pattern.
   - Simultaneous fault and fault_clr → fault_latched remains 1.
5. en dropped mid-period → next edge cnt=0 and all outputs 0, with PWM_synch low. en raised → shadows hold the current inputs and the first period starts at cnt=0.
6. rst_n asserted at cnt=0x500 with PWM2=1 → all outputs 0 immediately and the fault state cleared; after release the counting restarts at 0.
